// File: rtl/life_pkg.sv
// Shared constants and helpers for the Game of Life engine.
// Bit order: cell (r,c) sits at bit rows*cols-1-(r*cols+c), so row 0 is in the MSBs.
package life_pkg;

   localparam logic [3:0] BIRTH      = 4'd3;
   localparam logic [3:0] SURVIVE_LO = 4'd2;
   localparam logic [3:0] SURVIVE_HI = 4'd3;

   function automatic int unsigned cell_idx(input int unsigned r, input int unsigned c,
                                            input int unsigned rows, input int unsigned cols);
      return rows * cols - 1 - (r * cols + c);
   endfunction

endpackage

// File: rtl/life_cell_next.sv
// One cell's B3/S23 next-state decision from itself and its eight neighbours.
module life_cell_next
   import life_pkg::*;
(
   input  logic       i_self,
   input  logic [7:0] i_nbr,
   output logic       o_next
);

   logic [3:0] w_cnt;

   always_comb begin
      w_cnt = '0;
      for (int k = 0; k < 8; k++) begin
         w_cnt = w_cnt + {3'b000, i_nbr[k]};
      end
   end

   assign o_next = i_self ? ((w_cnt >= SURVIVE_LO) && (w_cnt <= SURVIVE_HI))
                          : (w_cnt == BIRTH);

endmodule

// File: rtl/life_engine.sv
// ROWS x COLS Game of Life grid with run/step control, generation counter and
// stable / period-2 / extinction flags; optional halt once the pattern is stable.
module life_engine
   import life_pkg::*;
#(
   parameter int unsigned ROWS  = 16,
   parameter int unsigned COLS  = 16,
   parameter int unsigned GEN_W = 16
) (
   input  logic                 clk,
   input  logic                 floprReset,
   input  logic [ROWS*COLS-1:0] seed,
   input  logic                 load,
   input  logic                 run,
   input  logic                 step,
   input  logic                 wrap,
   input  logic                 halt_on_stable,
   output logic [ROWS*COLS-1:0] grid_out,
   output logic [GEN_W-1:0]     gen_count,
   output logic                 stable,
   output logic                 osc2,
   output logic                 extinct
);

   localparam int unsigned N = ROWS * COLS;

   logic [N-1:0]     r_grid;
   logic [N-1:0]     r_prev;
   logic [N-1:0]     w_next;
   logic [GEN_W-1:0] r_gen;
   logic             r_stable;
   logic             r_osc2;
   logic             r_extinct;
   logic             w_adv;

   for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
      for (genvar gc = 0; gc < COLS; gc++) begin : g_col
         localparam int unsigned SELF = cell_idx(gr, gc, ROWS, COLS);
         logic [7:0] w_nbr;

         // k walks the 3x3 window row-major; k==4 is the cell itself.
         for (genvar k = 0; k < 9; k++) begin : g_nb
            if (k != 4) begin : g_use
               localparam int RR = int'(gr) + k / 3 - 1;
               localparam int CC = int'(gc) + k % 3 - 1;
               localparam bit INSIDE = (RR >= 0) && (RR < int'(ROWS)) &&
                                       (CC >= 0) && (CC < int'(COLS));
               localparam int unsigned RW  = (RR + int'(ROWS)) % int'(ROWS);
               localparam int unsigned CW  = (CC + int'(COLS)) % int'(COLS);
               localparam int unsigned IDX = cell_idx(RW, CW, ROWS, COLS);
               localparam int unsigned SLOT = (k < 4) ? k : k - 1;
               if (INSIDE) begin : g_in
                  assign w_nbr[SLOT] = r_grid[IDX];
               end else begin : g_edge
                  assign w_nbr[SLOT] = wrap & r_grid[IDX];
               end
            end
         end

         life_cell_next u_cell (
            .i_self (r_grid[SELF]),
            .i_nbr  (w_nbr),
            .o_next (w_next[SELF])
         );
      end
   end

   assign w_adv = (run | step) & ~(halt_on_stable & r_stable);

   always_ff @(posedge clk or posedge floprReset) begin
      if (floprReset) begin
         r_grid    <= '0;
         r_prev    <= '0;
         r_gen     <= '0;
         r_stable  <= 1'b0;
         r_osc2    <= 1'b0;
         r_extinct <= 1'b1;
      end else if (load) begin
         r_grid    <= seed;
         r_prev    <= '0;
         r_gen     <= '0;
         r_stable  <= 1'b0;
         r_osc2    <= 1'b0;
         r_extinct <= (seed == '0);
      end else if (w_adv) begin
         r_grid    <= w_next;
         r_prev    <= r_grid;
         if (r_gen != {GEN_W{1'b1}}) begin
            r_gen <= r_gen + GEN_W'(1);
         end
         r_stable  <= (w_next == r_grid);
         r_osc2    <= (w_next == r_prev) && (w_next != r_grid);
         r_extinct <= (w_next == '0);
      end
   end

   assign grid_out  = r_grid;
   assign gen_count = r_gen;
   assign stable    = r_stable;
   assign osc2      = r_osc2;
   assign extinct   = r_extinct;

endmodule
